// File: rtl/anc_pkg.sv
// Shared ANC datapath definitions: default filter geometry, sample/weight types
// and the tap-sequencer state encoding used by the MAC, LMS update and sequencer.
package anc_pkg;

  localparam int NTAPS = 32;
  localparam int DW    = 11;
  localparam int AW    = 5;

  typedef logic [DW-1:0] sample_t;
  typedef logic [DW-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/anc_tap_ram.sv
// Simple dual-port synchronous RAM, one write and one registered read port, write-first.
// A read cycle without rd_en returns zero so the read register doubles as a gated output.
module anc_tap_ram
  import anc_pkg::*;
#(
  parameter int DATA_W = 11,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Array contents are never reset so the weights survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_en) begin
      rd_data_d = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/anc_tap_sequencer.sv
// Tap-feed sequencer for the ANC FIR MAC: keeps the sample delay line and weight RAM,
// and streams (x[n-k], w[k]) pairs inside a FilterEN window after every new sample.
module anc_tap_sequencer
  import anc_pkg::*;
#(
  parameter int NTAPS = anc_pkg::NTAPS,
  parameter int AW    = $clog2(NTAPS),
  parameter int DW    = anc_pkg::DW
) (
  input  logic          Clk_100M,
  input  logic          Reset_N,
  input  logic [DW-1:0] Sample_In,
  input  logic          Sample_Vld_In,
  input  logic          Wz_Wr_En_In,
  input  logic [AW-1:0] Wz_Wr_Addr_In,
  input  logic [DW-1:0] Wz_Wr_Data_In,
  output logic [DW-1:0] Sig_Out,
  output logic [DW-1:0] Wz_Out,
  output logic          FilterEN_Out,
  output logic          Synch_Out,
  output logic          Busy_Out,
  output logic          Done_Out,
  output logic          Overrun_Out
);

  localparam logic [AW-1:0] LAST_K = AW'(NTAPS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] scrub_cnt_q, scrub_cnt_d;
  logic          scrub_q, scrub_d;
  logic          filter_en_q, filter_en_d;
  logic          synch_q, synch_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;

  logic          accept;
  logic          dl_wr_en;
  logic [AW-1:0] dl_wr_addr;
  logic [DW-1:0] dl_wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_k;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    base_d      = base_q;
    k_d         = k_q;
    scrub_cnt_d = scrub_cnt_q;
    scrub_d     = scrub_q;
    overrun_d   = overrun_q;
    dl_wr_en    = 1'b0;
    dl_wr_addr  = wr_ptr_q;
    dl_wr_data  = Sample_In;
    rd_en       = 1'b0;
    rd_k        = k_q + AW'(1);
    accept      = Sample_Vld_In && (state_q == IDLE) && !scrub_q;

    // Post-reset sweep zeroes one delay slot per cycle; samples are refused meanwhile.
    if (scrub_q) begin
      dl_wr_en    = 1'b1;
      dl_wr_addr  = scrub_cnt_q;
      dl_wr_data  = '0;
      scrub_cnt_d = scrub_cnt_q + AW'(1);
      if (scrub_cnt_q == LAST_K) begin
        scrub_d = 1'b0;
      end
    end

    if (Sample_Vld_In && !accept) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          dl_wr_en = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          base_d   = wr_ptr_q;
          state_d  = SYNC;
        end
      end
      SYNC: begin
        rd_en   = 1'b1;
        rd_k    = '0;
        k_d     = '0;
        state_d = FEED;
      end
      FEED: begin
        // Prefetch tap k+1 so its data lands exactly when the counter reaches it.
        if (k_q == LAST_K) begin
          state_d = DRAIN;
        end else begin
          rd_en = 1'b1;
          k_d   = k_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    filter_en_d = (state_d == SYNC) || (state_d == FEED);
    synch_d     = (state_d == SYNC);
    done_d      = (state_d == DRAIN);
    busy_d      = scrub_q || (state_d != IDLE);
  end

  always_ff @(posedge Clk_100M or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      base_q      <= '0;
      k_q         <= '0;
      scrub_cnt_q <= '0;
      scrub_q     <= 1'b1;
      filter_en_q <= 1'b0;
      synch_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      base_q      <= base_d;
      k_q         <= k_d;
      scrub_cnt_q <= scrub_cnt_d;
      scrub_q     <= scrub_d;
      filter_en_q <= filter_en_d;
      synch_q     <= synch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  anc_tap_ram #(.DATA_W(DW), .ADDR_W(AW)) u_delay_ram (
    .clk     (Clk_100M),
    .rst_n   (Reset_N),
    .wr_en   (dl_wr_en),
    .wr_addr (dl_wr_addr),
    .wr_data (dl_wr_data),
    .rd_en   (rd_en),
    .rd_addr (base_q - rd_k),
    .rd_data (Sig_Out)
  );

  anc_tap_ram #(.DATA_W(DW), .ADDR_W(AW)) u_weight_ram (
    .clk     (Clk_100M),
    .rst_n   (Reset_N),
    .wr_en   (Wz_Wr_En_In),
    .wr_addr (Wz_Wr_Addr_In),
    .wr_data (Wz_Wr_Data_In),
    .rd_en   (rd_en),
    .rd_addr (rd_k),
    .rd_data (Wz_Out)
  );

  assign FilterEN_Out = filter_en_q;
  assign Synch_Out    = synch_q;
  assign Busy_Out     = busy_q;
  assign Done_Out     = done_q;
  assign Overrun_Out  = overrun_q;

endmodule
